sr_latch: RTL and testbench

SR_LATCH -- requirements
Module: sr_latch

---
 rtl/sr_latch.sv | 73 +++++++
 tb/tb_sr_latch.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sr_latch.sv
// sr_latch: clocked array of independent set/reset bit-cells.
// Every bit samples its own s/r pair on the rising clock edge when enable is high.
// Asserting s and r together is a forbidden request. It leaves the bit unchanged,
// raises a one-cycle invalid flag for that bit, and sets a sticky summary flag
// that only rst clears.
module sr_latch #(
  parameter int                 WIDTH  = 1,
  parameter logic [WIDTH-1:0]   INIT_Q = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             enable,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] invalid,
  output logic             invalid_sticky
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] invalid_d;
  logic [WIDTH-1:0] invalid_q;
  logic             sticky_d;
  logic             sticky_q;

  // Next-state logic: per-bit set/reset decode, gated by enable.
  always_comb begin
    q_d       = q_q;
    invalid_d = {WIDTH{1'b0}};
    sticky_d  = sticky_q;
    if (enable) begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({s[i], r[i]})
          2'b10:   q_d[i] = 1'b1;
          2'b01:   q_d[i] = 1'b0;
          2'b11: begin
            // Forbidden request: hold the bit and flag it.
            q_d[i]       = q_q[i];
            invalid_d[i] = 1'b1;
          end
          default: q_d[i] = q_q[i];
        endcase
      end
      sticky_d = sticky_q | (|invalid_d);
    end else begin
      // Disabled: state holds; invalid drops back to zero via its default.
      q_d      = q_q;
      sticky_d = sticky_q;
    end
  end

  // State registers; rst acts immediately and wins over any same-edge update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q       <= INIT_Q;
      invalid_q <= {WIDTH{1'b0}};
      sticky_q  <= 1'b0;
    end else begin
      q_q       <= q_d;
      invalid_q <= invalid_d;
      sticky_q  <= sticky_d;
    end
  end

  // qn is taken straight from the q flops so it can never disagree with q.
  assign q              = q_q;
  assign qn             = ~q_q;
  assign invalid        = invalid_q;
  assign invalid_sticky = sticky_q;

endmodule

// File: tb/tb_sr_latch.sv
// Directed testbench for sr_latch.
// Instance u_w1 uses the default parameters: one bit, initial value 0.
// Instance u_w4 uses four bits with INIT_Q = 4'b1010.
module tb_sr_latch;

  logic       clk;
  logic       rst1, s1, r1, en1;
  logic       q1, qn1, inv1, stk1;
  logic       rst4, en4;
  logic [3:0] s4, r4, q4, qn4, inv4;
  logic       stk4;

  int total;
  int bad;

  sr_latch u_w1 (
    .clk(clk), .rst(rst1), .s(s1), .r(r1), .enable(en1),
    .q(q1), .qn(qn1), .invalid(inv1), .invalid_sticky(stk1)
  );

  sr_latch #(.WIDTH(4), .INIT_Q(4'b1010)) u_w4 (
    .clk(clk), .rst(rst4), .s(s4), .r(r4), .enable(en4),
    .q(q4), .qn(qn4), .invalid(inv4), .invalid_sticky(stk4)
  );

  // Free-running clock with a period of 10 time units.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Wait for the next rising edge, then settle one unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic eq, input logic einv, input logic estk);
    check({tag, ".q"},   {31'd0, q1},   {31'd0, eq});
    check({tag, ".qn"},  {31'd0, qn1},  {31'd0, ~eq});
    check({tag, ".inv"}, {31'd0, inv1}, {31'd0, einv});
    check({tag, ".stk"}, {31'd0, stk1}, {31'd0, estk});
  endtask

  task automatic chk4(input string tag, input logic [3:0] eq, input logic [3:0] einv, input logic estk);
    check({tag, ".q"},   {28'd0, q4},   {28'd0, eq});
    check({tag, ".qn"},  {28'd0, qn4},  {28'd0, ~eq});
    check({tag, ".inv"}, {28'd0, inv4}, {28'd0, einv});
    check({tag, ".stk"}, {31'd0, stk4}, {31'd0, estk});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst1 = 1'b1; s1 = 1'b0; r1 = 1'b0; en1 = 1'b0;
    rst4 = 1'b1; s4 = 4'd0; r4 = 4'd0; en4 = 1'b0;
    #2;
    chk1("w1_reset", 1'b0, 1'b0, 1'b0);
    chk4("w4_reset", 4'b1010, 4'b0000, 1'b0);

    // Release both resets between clock edges.
    @(negedge clk);
    rst1 = 1'b0;
    rst4 = 1'b0;

    // A set request with enable low must be ignored.
    en1 = 1'b0; s1 = 1'b1; r1 = 1'b0;
    tick();
    chk1("dis_set", 1'b0, 1'b0, 1'b0);

    // Hold, then reset, starting from q=0.
    en1 = 1'b1; s1 = 1'b0; r1 = 1'b0;
    tick();
    chk1("hold0", 1'b0, 1'b0, 1'b0);
    s1 = 1'b0; r1 = 1'b1;
    tick();
    chk1("reset0", 1'b0, 1'b0, 1'b0);

    // Set request: q must not change before the next rising edge.
    s1 = 1'b1; r1 = 1'b0;
    #2;
    chk1("no_transp", 1'b0, 1'b0, 1'b0);
    tick();
    chk1("set", 1'b1, 1'b0, 1'b0);
    s1 = 1'b0;
    tick();
    chk1("hold1a", 1'b1, 1'b0, 1'b0);
    tick();
    chk1("hold1b", 1'b1, 1'b0, 1'b0);

    // Forbidden s=r=1: q holds, invalid pulses for one cycle, sticky latches.
    s1 = 1'b1; r1 = 1'b1;
    tick();
    chk1("forbid", 1'b1, 1'b1, 1'b1);
    s1 = 1'b0; r1 = 1'b0;
    tick();
    chk1("forbid_after", 1'b1, 1'b0, 1'b1);

    // invalid clears on an edge with enable low.
    s1 = 1'b1; r1 = 1'b1;
    tick();
    chk1("forbid2", 1'b1, 1'b1, 1'b1);
    en1 = 1'b0;
    tick();
    chk1("dis_clr_inv", 1'b1, 1'b0, 1'b1);

    // Reset from q=1.
    en1 = 1'b1; s1 = 1'b0; r1 = 1'b1;
    tick();
    chk1("reset1", 1'b0, 1'b0, 1'b1);

    // A set request with rst held across the edge must be overridden.
    s1 = 1'b1; r1 = 1'b0;
    #2;
    rst1 = 1'b1;
    #1;
    chk1("async_rst", 1'b0, 1'b0, 1'b0);
    tick();
    chk1("rst_held", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst1 = 1'b0;
    tick();
    chk1("post_rst", 1'b1, 1'b0, 1'b0);

    // Wide instance: bit 0 set, bit 3 reset, bits 1 and 2 hold.
    en4 = 1'b1; s4 = 4'b0001; r4 = 4'b1000;
    tick();
    chk4("w4_mix", 4'b0011, 4'b0000, 1'b0);
    // Forbidden on bit 2 only; the other bits stay independent.
    s4 = 4'b0100; r4 = 4'b0100;
    tick();
    chk4("w4_forbid", 4'b0011, 4'b0100, 1'b1);
    // Reset asserted between edges acts at once.
    s4 = 4'd0; r4 = 4'd0;
    #2;
    rst4 = 1'b1;
    #1;
    chk4("w4_async_rst", 4'b1010, 4'b0000, 1'b0);
    @(negedge clk);
    rst4 = 1'b0;
    // Bit 3 set, bit 2 forbidden, bit 1 reset, bit 0 hold.
    s4 = 4'b1100; r4 = 4'b0110;
    tick();
    chk4("w4_all", 4'b1000, 4'b0100, 1'b1);
    en4 = 1'b0; s4 = 4'b0111; r4 = 4'b0000;
    tick();
    chk4("w4_dis", 4'b1000, 4'b0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
